// File: rtl/mealy_seq_detect.sv
// Mealy serial pattern detector whose KMP transition table is built at elaboration.
// Define MEALY_SEQ_COUNT_EN to build the saturating match counter; otherwise match_count is tied to 0.
module mealy_seq_detect #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1010,
    parameter int             OVERLAP = 1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             data,
    output logic             detected,
    output logic [CNT_W-1:0] match_count
);

    localparam int SW = $clog2(N);

    generate
        if (N < 2 || N > 16) begin : g_bad_n
            $error("mealy_seq_detect: N must be in 2..16");
        end
        if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
            $error("mealy_seq_detect: CNT_W must be in 1..32");
        end
    endgenerate

    // Next state after receiving bit b with s pattern bits matched. Covers the
    // extend case, the KMP fallback on a mismatch, and the post-match state.
    function automatic int kmp_next(input int s, input logic b);
        logic [15:0] str;
        int          result;
        logic        ok;
        str    = '0;
        result = 0;
        for (int i = 0; i < 16; i++) begin
            if (i < s) str[i] = PATTERN[N-1-i];
        end
        str[s] = b;
        if (s < N - 1 && b == PATTERN[N-1-s]) begin
            result = s + 1;
        end else if (s == N - 1 && b == PATTERN[0] && OVERLAP == 0) begin
            result = 0;
        end else begin
            for (int k = 1; k < 16; k++) begin
                if (k <= s) begin
                    ok = 1'b1;
                    for (int j = 0; j < 16; j++) begin
                        if (j < k && str[s+1-k+j] != PATTERN[N-1-j]) ok = 1'b0;
                    end
                    if (ok) result = k;
                end
            end
        end
        return result;
    endfunction

    logic [SW-1:0] nxt0 [N];
    logic [SW-1:0] nxt1 [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_tbl
            assign nxt0[gi] = SW'(kmp_next(gi, 1'b0));
            assign nxt1[gi] = SW'(kmp_next(gi, 1'b1));
        end
    endgenerate

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic          detected_q;
    logic          match;

    always_comb begin
        state_d = state_q;
        match   = 1'b0;
        if (en) begin
            state_d = '0;
            for (int i = 0; i < N; i++) begin
                if (state_q == SW'(i)) state_d = data ? nxt1[i] : nxt0[i];
            end
            match = (state_q == SW'(N - 1)) && (data == PATTERN[0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= '0;
            detected_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            detected_q <= match;
        end
    end

    assign detected = detected_q;

`ifdef MEALY_SEQ_COUNT_EN
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (match && count_q != {CNT_W{1'b1}}) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign match_count = count_q;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_mealy_seq_detect.sv
// Bench for mealy_seq_detect: four configurations driven in lockstep, checked against
// a shift-register pattern model, directed vector tables and random traffic.
module tb_mealy_seq_detect;

`ifdef MEALY_SEQ_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       data = 1'b0;
    logic       det0, det1, det2, det3;
    logic [7:0] cnt0, cnt1, cnt2;
    logic [1:0] cnt3;

    always #5 clk = ~clk;

    mealy_seq_detect u_def (
        .clk(clk), .rst(rst), .en(en), .data(data), .detected(det0), .match_count(cnt0));
    mealy_seq_detect #(.OVERLAP(0)) u_novl (
        .clk(clk), .rst(rst), .en(en), .data(data), .detected(det1), .match_count(cnt1));
    mealy_seq_detect #(.N(3), .PATTERN(3'b111), .OVERLAP(1)) u_111 (
        .clk(clk), .rst(rst), .en(en), .data(data), .detected(det2), .match_count(cnt2));
    mealy_seq_detect #(.CNT_W(2)) u_cw2 (
        .clk(clk), .rst(rst), .en(en), .data(data), .detected(det3), .match_count(cnt3));

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: sliding window over the sampled bits, per configuration.
    int c_n   [4] = '{4, 4, 3, 4};
    int c_pat [4] = '{10, 10, 7, 10};
    bit c_ov  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int c_cw  [4] = '{8, 8, 8, 2};
    int m_hist [4];
    int m_valid[4];
    int m_since[4];
    int m_cnt  [4];
    bit m_det  [4];

    function automatic bit get_det(input int i);
        case (i)
            0: return det0;
            1: return det1;
            2: return det2;
            default: return det3;
        endcase
    endfunction

    function automatic int get_cnt(input int i);
        case (i)
            0: return int'(cnt0);
            1: return int'(cnt1);
            2: return int'(cnt2);
            default: return int'(cnt3);
        endcase
    endfunction

    task automatic model_edge(input bit r, input bit e, input bit d);
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                m_hist[i] = 0; m_valid[i] = 0; m_since[i] = 0; m_cnt[i] = 0; m_det[i] = 1'b0;
            end else if (!e) begin
                m_det[i] = 1'b0;
            end else begin
                m_hist[i]  = ((m_hist[i] << 1) | int'(d)) & 16'hFFFF;
                if (m_valid[i] < 100) m_valid[i]++;
                if (m_since[i] < 100) m_since[i]++;
                m_det[i] = (m_valid[i] >= c_n[i])
                        && ((m_hist[i] & ((1 << c_n[i]) - 1)) == c_pat[i])
                        && (c_ov[i] || m_since[i] >= c_n[i]);
                if (m_det[i]) begin
                    if (m_cnt[i] < (1 << c_cw[i]) - 1) m_cnt[i]++;
                    if (!c_ov[i]) m_since[i] = 0;
                end
            end
        end
    endtask

    task automatic check_bit(input string name, input bit got, input bit exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0b expected %0b", name, cyc, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    // One transaction: drive, clock, then compare every instance against the model.
    task automatic step(input bit r, input bit e, input bit d);
        rst = r; en = e; data = d;
        @(posedge clk);
        model_edge(r, e, d);
        #1;
        cyc++;
        $display("cyc %0d rst=%0b en=%0b data=%0b det=%0b%0b%0b%0b cnt=%0d/%0d/%0d/%0d",
                 cyc, r, e, d, det0, det1, det2, det3, cnt0, cnt1, cnt2, cnt3);
        for (int i = 0; i < 4; i++) begin
            check_bit($sformatf("model_det[%0d]", i), get_det(i), m_det[i]);
            check_int($sformatf("model_cnt[%0d]", i), get_cnt(i), CNT_ON ? m_cnt[i] : 0);
        end
    endtask

    typedef struct {
        bit r, e, d;
        bit d0; int c0;
        bit d1; int c1;
    } vec_t;

    vec_t tbl[22];

    initial begin
        // r e d | default det,cnt | non-overlap det,cnt
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 1, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, 0, 1, 1, 1, 1};
        tbl[5]  = '{0, 1, 1, 0, 1, 0, 1};
        tbl[6]  = '{0, 1, 0, 1, 2, 0, 1};
        tbl[7]  = '{0, 1, 1, 0, 2, 0, 1};
        tbl[8]  = '{1, 1, 1, 0, 0, 0, 0};
        tbl[9]  = '{0, 1, 1, 0, 0, 0, 0};
        tbl[10] = '{0, 1, 0, 0, 0, 0, 0};
        tbl[11] = '{0, 1, 1, 0, 0, 0, 0};
        tbl[12] = '{1, 1, 0, 0, 0, 0, 0};
        tbl[13] = '{0, 1, 0, 0, 0, 0, 0};
        tbl[14] = '{1, 0, 0, 0, 0, 0, 0};
        tbl[15] = '{0, 1, 1, 0, 0, 0, 0};
        tbl[16] = '{0, 1, 0, 0, 0, 0, 0};
        tbl[17] = '{0, 1, 1, 0, 0, 0, 0};
        tbl[18] = '{0, 0, 1, 0, 0, 0, 0};
        tbl[19] = '{0, 0, 1, 0, 0, 0, 0};
        tbl[20] = '{0, 0, 1, 0, 0, 0, 0};
        tbl[21] = '{0, 1, 0, 1, 1, 1, 1};

        for (int i = 0; i < 4; i++) begin
            m_hist[i] = 0; m_valid[i] = 0; m_since[i] = 0; m_cnt[i] = 0; m_det[i] = 1'b0;
        end

        for (int k = 0; k < 22; k++) begin
            step(tbl[k].r, tbl[k].e, tbl[k].d);
            check_bit($sformatf("tbl%0d_det_def", k), det0, tbl[k].d0);
            check_int($sformatf("tbl%0d_cnt_def", k), int'(cnt0), CNT_ON ? tbl[k].c0 : 0);
            check_bit($sformatf("tbl%0d_det_novl", k), det1, tbl[k].d1);
            check_int($sformatf("tbl%0d_cnt_novl", k), int'(cnt1), CNT_ON ? tbl[k].c1 : 0);
        end

        // 111 with overlap: pulses on bits 3..6, back to back.
        step(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 1'b1, 1'b1);
            check_bit($sformatf("p111_det_bit%0d", k), det2, k >= 3);
            check_int($sformatf("p111_cnt_bit%0d", k), int'(cnt2), CNT_ON ? ((k >= 3) ? k - 2 : 0) : 0);
        end

        // Five matches of 1010 with overlap: 2-bit counter saturates at 3.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 1'b1);
            step(1'b0, 1'b1, 1'b0);
            check_bit($sformatf("sat_det_m%0d", k + 1), det3, 1'b1);
            check_int($sformatf("sat_cnt2_m%0d", k + 1), int'(cnt3), CNT_ON ? ((k + 1 > 3) ? 3 : k + 1) : 0);
        end
        check_int("sat_cnt8_final", int'(cnt0), CNT_ON ? 5 : 0);

        // Random traffic against the model.
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 3) != 0, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mealy_seq_detect.md
MEALY_SEQ_DETECT -- requirements
Module: mealy_seq_detect

Interface
REQ-001 The block SHALL provide parameter N, default 4: pattern length in bits, legal range 2..16.
REQ-002 The block SHALL provide parameter PATTERN [N-1:0], default 4'b1010: target sequence; PATTERN[N-1] is received first.
REQ-003 The block SHALL provide parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping.
REQ-004 The block SHALL provide parameter CNT_W, default 8: match counter width, legal range 1..32.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port en, input, 1 bit: data qualifier; data is sampled only when en=1.
REQ-008 The block SHALL have port data, input, 1 bit: serial input bit.
REQ-009 The block SHALL have port detected, output, 1 bit: registered one-cycle match pulse.
REQ-010 The block SHALL have port match_count, output, CNT_W bits: saturating count of matches.

Function
REQ-011 State SHALL be the count of pattern bits currently matched, range 0..N-1, width clog2(N).
REQ-012 On a sampled bit that extends the match with state < N-1, state SHALL increment by 1.
REQ-013 On a sampled mismatching bit, next state SHALL be the length of the longest proper suffix of (matched prefix + data) that is also a prefix of PATTERN (KMP fallback, computed at elaboration, never at run time); e.g. PATTERN 1010, state 3, data 1 -> state 1.
REQ-014 A sampled bit completing the pattern in state N-1 SHALL be a match.
REQ-015 On a match with OVERLAP=1, next state SHALL be the longest proper border of PATTERN (1010 -> 2); with OVERLAP=0, next state SHALL be 0.
REQ-016 detected SHALL be 1 in exactly the cycle following the edge at which a match is sampled, and 0 otherwise.
REQ-017 When en=0, state SHALL hold, data SHALL be ignored, and no match SHALL be generated; detected SHALL be 0 in the following cycle.
REQ-018 Back-to-back matches (overlap with border N-1, e.g. 1111) SHALL produce detected high on consecutive cycles.
REQ-019 match_count SHALL increment by 1 per match and saturate at 2^CNT_W-1 with no wrap.
REQ-020 Illegal N, or CNT_W outside its legal range, SHALL fail elaboration.

Reset
REQ-021 With rst=1 at a clock edge, state SHALL become 0, detected 0 and match_count 0, regardless of en and data.
REQ-022 rst SHALL take priority over a simultaneous match; a partial match in progress SHALL be discarded.
REQ-023 The first bit sampled after rst deasserts SHALL be treated as pattern bit PATTERN[N-1] candidate from state 0.

Configuration
REQ-024 Macro MEALY_SEQ_COUNT_EN SHALL control the match counter feature.
REQ-025 With MEALY_SEQ_COUNT_EN defined, match_count SHALL behave as in REQ-019.
REQ-026 Without MEALY_SEQ_COUNT_EN, no counter register SHALL be built, the match_count port SHALL remain, and it SHALL be tied to 0; detection behaviour SHALL be unchanged.

Verification
REQ-027 Defaults, en=1, stream 1,0,1,0,1,0,1 SHALL give detected pulses after bit 4 and after bit 6, and match_count=2.
REQ-028 OVERLAP=0, same stream SHALL give a single pulse after bit 4, and match_count=1.
REQ-029 Defaults, stream 1,0,1, then rst=1 for one cycle, then 0 SHALL give no pulse and match_count=0.
REQ-030 Defaults, stream 1,0,1 then en=0 for 3 cycles (data=1) then en=1 with 0 SHALL give one pulse after the final 0.
REQ-031 N=3, PATTERN=111, OVERLAP=1, six 1s SHALL give pulses after bits 3, 4, 5 and 6, on consecutive cycles.
REQ-032 CNT_W=2 with MEALY_SEQ_COUNT_EN, 5 matches SHALL give match_count=3; without the macro, match_count SHALL stay 0 throughout.
